// File: rtl/uvmt_i2c_st_clknrst_rcvr.sv
// Clock/reset receiver: synchronizes and stretches reset_n into sys_rst_n, services sw reset requests.
// Optional uptime counter is enabled by defining UVMT_I2C_ST_CLKNRST_RCVR_UPTIME_EN.
module uvmt_i2c_st_clknrst_rcvr #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned STRETCH_CYCLES = 16,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sw_rst_req,
   output logic             sys_rst_n,
   output logic             ready,
   output logic             rst_done,
   output logic             sw_rst_ack,
   output logic [CNT_W-1:0] sw_rst_cnt,
   output logic [CNT_W-1:0] uptime
);

   localparam int unsigned      ST_W    = (STRETCH_CYCLES < 2) ? 1 : $clog2(STRETCH_CYCLES);
   localparam logic [ST_W-1:0]  ST_LAST = ST_W'((STRETCH_CYCLES == 0) ? 0 : STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ASSERTED, STRETCH, RUN, SW_RST} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic [ST_W-1:0]        st_cnt;
   logic                   sync_done_c;

   // Reset-deassert synchronizer shifting in a constant 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], 1'b1};
   end

   // The top stage goes high on this edge when the stage below it is already high
   assign sync_done_c = sync[SYNC_STAGES-2] | sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ASSERTED;
         st_cnt     <= '0;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         rst_done   <= 1'b0;
         sw_rst_ack <= 1'b0;
         sw_rst_cnt <= '0;
      end else begin
         rst_done   <= 1'b0;
         sw_rst_ack <= 1'b0;
         case (state)
            ASSERTED: begin
               if (sync_done_c) begin
                  st_cnt <= '0;
                  if (STRETCH_CYCLES == 0) begin
                     state     <= RUN;
                     sys_rst_n <= 1'b1;
                     ready     <= 1'b1;
                     rst_done  <= 1'b1;
                  end else begin
                     state <= STRETCH;
                  end
               end
            end
            STRETCH: begin
               if (st_cnt == ST_LAST) begin
                  state     <= RUN;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
                  rst_done  <= 1'b1;
               end else begin
                  st_cnt <= st_cnt + 1'b1;
               end
            end
            RUN: begin
               if (sw_rst_req) begin
                  state      <= SW_RST;
                  sys_rst_n  <= 1'b0;
                  ready      <= 1'b0;
                  sw_rst_ack <= 1'b1;
                  if (sw_rst_cnt != CNT_MAX) sw_rst_cnt <= sw_rst_cnt + 1'b1;
               end
            end
            SW_RST: begin
               st_cnt <= '0;
               if (STRETCH_CYCLES == 0) begin
                  state     <= RUN;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
                  rst_done  <= 1'b1;
               end else begin
                  state <= STRETCH;
               end
            end
            default: state <= ASSERTED;
         endcase
      end
   end

`ifdef UVMT_I2C_ST_CLKNRST_RCVR_UPTIME_EN
   // Cycles in RUN since the last sys_rst_n rise; cleared on the edge that leaves RUN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uptime <= '0;
      end else if (state == RUN) begin
         if (sw_rst_req)              uptime <= '0;
         else if (uptime != CNT_MAX)  uptime <= uptime + 1'b1;
      end else begin
         uptime <= '0;
      end
   end
`else
   assign uptime = '0;
`endif

endmodule
